// File: rtl/control_word_sequencer_pkg.sv
// Shared constants for the LEGv8-subset control sequencer.
// Branch decode is enabled by defining CONTROL_SEQ_BRANCH_EN.
package control_word_sequencer_pkg;

  localparam logic [4:0] XZR = 5'd31;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01010;

  localparam logic [9:0] OP_ADDI = 10'b1001000100;
  localparam logic [9:0] OP_SUBI = 10'b1101000100;
  localparam logic [9:0] OP_ANDI = 10'b1001001000;
  localparam logic [9:0] OP_ORRI = 10'b1011001000;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;

  localparam logic [8:0] OP_MOVZ = 9'b110100101;
  localparam logic [5:0] OP_B    = 6'b000101;
  localparam logic [7:0] OP_CBZ  = 8'b10110100;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  typedef enum logic [1:0] {
    BR_NONE,
    BR_B,
    BR_CBZ
  } br_kind_t;

  typedef struct packed {
    logic        w;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  da;
    logic [4:0]  fs;
    logic [63:0] k;
    logic        k_sel;
    logic        c0;
    logic        en_alu;
    logic        en_b;
  } ctrl_word_t;

  localparam ctrl_word_t CW_IDLE = '{
    w: 1'b0, sa: XZR, sb: XZR, da: XZR, fs: 5'd0,
    k: 64'd0, k_sel: 1'b0, c0: 1'b0, en_alu: 1'b0, en_b: 1'b0
  };

endpackage

// File: rtl/control_word_sequencer_decoder.sv
// Combinational IR decode into a datapath control word and branch info.
// B/CBZ decode only when CONTROL_SEQ_BRANCH_EN is defined.
module control_word_decoder
  import control_word_sequencer_pkg::*;
(
  input  logic [31:0] ir,
  output ctrl_word_t  cw,
  output br_kind_t    br,
  output logic [31:0] offset,
  output logic        halt,
  output logic        illegal
);

  logic [9:0]  op10;
  logic [10:0] op11;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;

  assign op10 = ir[31:22];
  assign op11 = ir[31:21];
  assign rd   = ir[4:0];
  assign rn   = ir[9:5];
  assign rm   = ir[20:16];

  always_comb begin
    cw      = CW_IDLE;
    br      = BR_NONE;
    offset  = '0;
    halt    = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      (ir == 32'h0): halt = 1'b1;
      (op10 == OP_ADDI || op10 == OP_SUBI ||
       op10 == OP_ANDI || op10 == OP_ORRI): begin
        cw.sa     = rn;
        cw.da     = rd;
        cw.k      = {52'd0, ir[21:10]};
        cw.k_sel  = 1'b1;
        cw.c0     = (op10 == OP_SUBI);
        cw.fs     = (op10 == OP_ADDI) ? FS_ADD :
                    (op10 == OP_SUBI) ? FS_SUB :
                    (op10 == OP_ANDI) ? FS_AND : FS_OR;
        cw.en_alu = 1'b1;
        cw.w      = 1'b1;
      end
      (op11 == OP_ADD || op11 == OP_SUB ||
       op11 == OP_AND || op11 == OP_ORR): begin
        cw.sa     = rn;
        cw.sb     = rm;
        cw.da     = rd;
        cw.c0     = (op11 == OP_SUB);
        cw.fs     = (op11 == OP_ADD) ? FS_ADD :
                    (op11 == OP_SUB) ? FS_SUB :
                    (op11 == OP_AND) ? FS_AND : FS_OR;
        cw.en_alu = 1'b1;
        cw.w      = 1'b1;
      end
      (ir[31:23] == OP_MOVZ): begin
        cw.sa     = XZR;
        cw.da     = rd;
        cw.k      = {48'd0, ir[20:5]} << {ir[22:21], 4'd0};
        cw.k_sel  = 1'b1;
        cw.fs     = FS_ADD;
        cw.en_alu = 1'b1;
        cw.w      = 1'b1;
      end
`ifdef CONTROL_SEQ_BRANCH_EN
      (ir[31:26] == OP_B): begin
        br     = BR_B;
        offset = {{6{ir[25]}}, ir[25:0]};
      end
      // Rt + 0 through the ALU drives Z back on Status[0]
      (ir[31:24] == OP_CBZ): begin
        cw.sa     = rd;
        cw.k_sel  = 1'b1;
        cw.fs     = FS_ADD;
        cw.en_alu = 1'b1;
        br        = BR_CBZ;
        offset    = {{13{ir[23]}}, ir[23:5]};
      end
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_word_sequencer.sv
// FETCH/EXEC/HALT sequencer owning PC, IR and halt status.
// Branches (B, CBZ) exist only when CONTROL_SEQ_BRANCH_EN is defined.
module control_word_sequencer
  import control_word_sequencer_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_data,
  input  logic [3:0]      Status,
  output logic            W,
  output logic [4:0]      SA,
  output logic [4:0]      SB,
  output logic [4:0]      DA,
  output logic [4:0]      FS,
  output logic [63:0]     K,
  output logic            K_SEL,
  output logic            C0,
  output logic            EN_ALU,
  output logic            EN_B,
  output logic            halted,
  output logic            illegal
);

  logic [1:0]      state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic [31:0]     ir;
  ctrl_word_t      dec_cw;
  ctrl_word_t      cw;
  br_kind_t        br;
  logic [31:0]     offset;
  logic            dec_halt;
  logic            dec_illegal;
  logic            exec;
  logic            unused_ok;

  control_word_decoder u_dec (
    .ir      (ir),
    .cw      (dec_cw),
    .br      (br),
    .offset  (offset),
    .halt    (dec_halt),
    .illegal (dec_illegal)
  );

  // Reset masks the EXEC word so no write strobe escapes a reset cycle
  assign exec = (state == ST_EXEC) && !rst;
  assign cw   = exec ? dec_cw : CW_IDLE;

  assign W      = cw.w;
  assign SA     = cw.sa;
  assign SB     = cw.sb;
  assign DA     = cw.da;
  assign FS     = cw.fs;
  assign K      = cw.k;
  assign K_SEL  = cw.k_sel;
  assign C0     = cw.c0;
  assign EN_ALU = cw.en_alu;
  assign EN_B   = cw.en_b;

  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;
  assign unused_ok = ^{offset, br, Status};

  always_comb begin
    pc_next = pc + PC_W'(1);
`ifdef CONTROL_SEQ_BRANCH_EN
    if (br == BR_B || (br == BR_CBZ && Status[0]))
      pc_next = pc + offset[PC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      pc      <= '0;
      ir      <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      unique case (state)
        ST_FETCH: begin
          if (imem_valid) begin
            ir    <= imem_data;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (dec_halt || dec_illegal) begin
            state   <= ST_HALT;
            halted  <= 1'b1;
            illegal <= dec_illegal;
          end else begin
            pc    <= pc_next;
            state <= ST_FETCH;
          end
        end
        default: state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_control_word_sequencer.sv
// Scoreboard bench: stimulus queues expected EXEC words and next-fetch state,
// a negedge monitor checks them when the DUT enters EXEC.
module tb_control_word_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_data = '0;
  logic [3:0]  Status = '0;
  logic        W, K_SEL, C0, EN_ALU, EN_B;
  logic [4:0]  SA, SB, DA, FS;
  logic [63:0] K;
  logic        halted, illegal;

  always #5 clk = ~clk;

  control_word_sequencer #(.PC_W(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .Status(Status),
    .W(W), .SA(SA), .SB(SB), .DA(DA), .FS(FS), .K(K),
    .K_SEL(K_SEL), .C0(C0), .EN_ALU(EN_ALU), .EN_B(EN_B),
    .halted(halted), .illegal(illegal)
  );

  typedef struct {
    logic        w;
    logic [4:0]  sa, sb, da, fs;
    logic [63:0] k;
    logic        k_sel, c0, en_alu;
    logic [15:0] next_addr;
    logic        next_req, hlt, ill;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   phase  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t ew(logic w, logic [4:0] sa, logic [4:0] sb,
                              logic [4:0] da, logic [4:0] fs,
                              logic [63:0] k, logic ks, logic c0,
                              logic en, logic [15:0] na);
    exp_t e;
    e.w = w; e.sa = sa; e.sb = sb; e.da = da; e.fs = fs; e.k = k;
    e.k_sel = ks; e.c0 = c0; e.en_alu = en;
    e.next_addr = na; e.next_req = 1'b1; e.hlt = 1'b0; e.ill = 1'b0;
    return e;
  endfunction

  function automatic exp_t ehalt(logic il);
    exp_t e;
    e = ew(0, 31, 31, 31, 0, 0, 0, 0, 0, 0);
    e.next_req = 1'b0; e.hlt = 1'b1; e.ill = il;
    return e;
  endfunction

  always @(negedge clk) begin
    if (phase == 1) begin
      if (q.size() == 0) begin
        chk("queue_nonempty", q.size(), 1);
      end else begin
        cur = q.pop_front();
        chk("W", W, cur.w);
        chk("SA", SA, cur.sa);
        chk("SB", SB, cur.sb);
        chk("DA", DA, cur.da);
        chk("FS", FS, cur.fs);
        chk("K", K, cur.k);
        chk("K_SEL", K_SEL, cur.k_sel);
        chk("C0", C0, cur.c0);
        chk("EN_ALU", EN_ALU, cur.en_alu);
        chk("exec_req", imem_req, 0);
      end
      phase = 2;
    end else begin
      if (phase == 2) begin
        chk("next_req", imem_req, cur.next_req);
        if (cur.next_req) chk("next_addr", imem_addr, cur.next_addr);
        chk("halted", halted, cur.hlt);
        chk("illegal", illegal, cur.ill);
        chk("post_W", W, 0);
      end
      phase = (imem_req && imem_valid && !rst) ? 1 : 0;
    end
  end

  task automatic issue(input logic [15:0] pc, input logic [31:0] word,
                       input int dly, input logic [3:0] st,
                       input exp_t e, input bit rst_exec = 0);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_wait", imem_req, 1);
    chk("fetch_addr", imem_addr, pc);
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      chk("stall_req", imem_req, 1);
    end
    q.push_back(e);
    imem_valid = 1'b1;
    imem_data  = word;
    Status     = st;
    @(posedge clk); #1;
    imem_valid = 1'b0;
    if (rst_exec) rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_req", imem_req, 1);
    chk("rst_addr", imem_addr, 0);
    chk("rst_W", W, 0);
    chk("rst_SA", SA, 31);
    chk("rst_DA", DA, 31);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
  endtask

  task automatic hold_halt();
    imem_valid = 1'b1;
    imem_data  = 32'h913FFFE1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("halt_req", imem_req, 0);
      chk("halt_W", W, 0);
      chk("halt_sticky", halted, 1);
    end
    imem_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    issue(0, 32'h913FFFE1, 0, 0, ew(1, 31, 31, 1, 5'b01000, 64'hFFF, 1, 0, 1, 1));
    issue(1, 32'hCB020024, 3, 0, ew(1, 1, 2, 4, 5'b01010, 0, 0, 1, 1, 2));
    issue(2, 32'hD2FFFFE3, 0, 0,
          ew(1, 31, 31, 3, 5'b01000, 64'hFFFF_0000_0000_0000, 1, 0, 1, 3));
    issue(3, 32'h9203C025, 1, 0, ew(1, 1, 31, 5, 5'b00000, 64'hF0, 1, 0, 1, 4));
    issue(4, 32'hAA020026, 0, 0, ew(1, 1, 2, 6, 5'b00100, 0, 0, 0, 1, 5));
    issue(5, 32'hB2000447, 2, 0, ew(1, 2, 31, 7, 5'b00100, 1, 1, 0, 1, 6));
    issue(6, 32'h8B040068, 0, 0, ew(1, 3, 4, 8, 5'b01000, 0, 0, 0, 1, 7));
    issue(7, 32'h8A0600A9, 0, 0, ew(1, 5, 6, 9, 5'b00000, 0, 0, 0, 1, 8));
    issue(8, 32'hD1048D4A, 0, 0, ew(1, 10, 31, 10, 5'b01010, 64'h123, 1, 1, 1, 9));
    issue(9, 32'h910003E0, 0, 0, ew(1, 31, 31, 0, 5'b01000, 0, 1, 0, 1, 10));
`ifdef CONTROL_SEQ_BRANCH_EN
    issue(10, 32'hB4FFFFC5, 0, 4'b0001, ew(0, 5, 31, 31, 5'b01000, 0, 1, 0, 1, 8));
    issue(8, 32'h910003E0, 0, 0, ew(1, 31, 31, 0, 5'b01000, 0, 1, 0, 1, 9));
    issue(9, 32'h910003E0, 0, 0, ew(1, 31, 31, 0, 5'b01000, 0, 1, 0, 1, 10));
    issue(10, 32'hB4FFFFC5, 0, 4'b0000, ew(0, 5, 31, 31, 5'b01000, 0, 1, 0, 1, 11));
    issue(11, 32'h17FFFFF3, 0, 0, ew(0, 31, 31, 31, 0, 0, 0, 0, 0, 16'hFFFE));
    issue(16'hFFFE, 32'h14000003, 1, 0, ew(0, 31, 31, 31, 0, 0, 0, 0, 0, 1));
    issue(1, 32'h913FFFE1, 0, 0, ew(0, 31, 31, 31, 0, 0, 0, 0, 0, 0), 1);
`else
    issue(10, 32'h14000003, 0, 0, ehalt(1));
    hold_halt();
    do_reset();
    issue(0, 32'h913FFFE1, 0, 0, ew(0, 31, 31, 31, 0, 0, 0, 0, 0, 0), 1);
`endif
    issue(0, 32'h00000000, 0, 0, ehalt(0));
    hold_halt();
    do_reset();
    issue(0, 32'hFFFFFFFF, 1, 0, ehalt(1));
    hold_halt();
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_word_sequencer.md
# control_word_sequencer

Multi-cycle control unit that fetches 32-bit LEGv8-subset instructions over a request/valid handshake and drives the control word (W, SA, SB, DA, FS, K, K_SEL, C0, EN_ALU, EN_B) of the register-file-and-ALU datapath. It sits upstream of that datapath, is the block that generates its control words, and closes the loop through the datapath's 4-bit Status for conditional branches. It owns the program counter and the halt/illegal-instruction status.

## Interface
- PC_W, 16, program counter width in words; imem_addr width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held until imem_valid
- imem_addr  out  PC_W  word address of requested instruction (= PC)
- imem_valid  in  1  imem_data valid this cycle; meaningful only while imem_req=1
- imem_data  in  32  instruction word
- Status  in  4  datapath flags {V,C,N,Z}; Z = Status[0]
- W, K_SEL, C0, EN_ALU, EN_B  out  1 each  datapath control bits
- SA, SB, DA  out  5 each  register selects; 31 = XZR
- FS  out  5  ALU function: FS[4:2] op (000 AND, 001 OR, 010 ADD, 011 XOR), FS[1] invert B, FS[0] invert A
- K  out  64  immediate to datapath
- halted  out  1  sticky; set by HALT or illegal instruction
- illegal  out  1  sticky; set by undecodable instruction

## Operation
- States: FETCH, EXEC, HALT. Reset -> FETCH, PC=0.
- FETCH: imem_req=1, imem_addr=PC; on imem_valid latch imem_data into IR, go EXEC. Control outputs idle (W=0, EN_ALU=0, EN_B=0, SA=SB=DA=31, FS=0, K=0, K_SEL=0, C0=0).
- EXEC (exactly one cycle): drive decoded control word from IR, then PC update, then FETCH (or HALT).
- Decode (Rd[4:0], Rn[9:5], Rm[20:16]):
  - ADDI 1001000100 / SUBI 1101000100: SA=Rn, DA=Rd, K=zero-extended imm12[21:10], K_SEL=1, FS=01000 (ADD) or 01010 with C0=1 (SUB), EN_ALU=1, W=1.
  - ANDI 1001001000 / ORRI 1011001000: as ADDI with FS=00000 / 00100.
  - ADD 10001011000 / SUB 11001011000 / AND 10001010000 / ORR 10101010000: SA=Rn, SB=Rm, K_SEL=0, FS as above, EN_ALU=1, W=1.
  - MOVZ 110100101: SA=31, K=imm16[20:5] << (16*hw[22:21]), K_SEL=1, FS=01000, DA=Rd, EN_ALU=1, W=1.
  - B 000101: W=0; PC <= PC + sign-extended imm26 (truncated to PC_W).
  - CBZ 10110100: SA=Rt[4:0], K=0, K_SEL=1, FS=01000, EN_ALU=1, W=0; if Status[0]=1 in EXEC, PC <= PC + sext(imm19[23:5]), else PC+1.
  - 32'h0000_0000: HALT; halted=1, PC unchanged.
  - Anything else: illegal=1, halted=1, W=0, PC unchanged.
- Non-branch instructions: PC <= PC+1, wraps modulo 2^PC_W.
- HALT: absorbing until rst; imem_req=0, outputs idle.

## Timing
- Minimum 2 cycles/instruction (FETCH with same-cycle imem_valid, then EXEC). Each extra cycle imem_valid is low adds one FETCH cycle.
- W high for exactly one cycle per register-writing instruction; the datapath writes on that cycle's rising edge.
- Status sampled at the end of the CBZ EXEC cycle (combinational datapath path).
- imem_valid while imem_req=0 is ignored.
- rst dominates everything, including mid-EXEC: W is forced to 0 in the reset cycle. Outputs are idle, PC=0, halted=0, illegal=0, state FETCH after the edge.

## Configuration
- CONTROL_SEQ_BRANCH_EN defined: B and CBZ decoded as above.
- Undefined: B/CBZ opcodes are illegal (illegal=1, halt). No adder for the branch target or Status sampling logic is synthesized. PC always increments.

## Structure
- Shared package: opcode constants, FS encodings, state enum, XZR=31.
- One sub-module, control_word_decoder (combinational IR -> control word + branch kind + offset). The sequencer FSM and PC stay in the top.

## Test plan
- Reset: rst=1 two cycles -> PC=0, W=0, SA=SB=DA=31, halted=0; first imem_req with imem_addr=0.
- ADDI X1,XZR,#0xFFF with imem_valid same cycle -> EXEC: SA=31, DA=1, K=0xFFF, K_SEL=1, FS=01000, W=1 for one cycle; next FETCH addr=1.
- SUB X4,X1,X2 with imem_valid delayed 3 cycles -> 3 extra FETCH cycles; EXEC: SA=1, SB=2, DA=4, FS=01010, C0=1, K_SEL=0.
- MOVZ X3,#0xFFFF,LSL#48 -> K=64'hFFFF_0000_0000_0000, DA=3, W=1.
- CBZ X5,#-2 at PC=10 with Status=0001 -> W=0, next addr=8; repeated with Status=0000 -> next addr=11; B #+3 at PC=0xFFFE -> addr=1 (wrap).
- Word 0x0000_0000 -> halted=1, imem_req=0 thereafter. Word 0xFFFF_FFFF -> illegal=1, halted=1. rst during EXEC of an ADDI -> no W pulse, PC=0.
